// File: rtl/food_spawner_if.sv
// food_spawner_if: occupancy-query handshake between the food spawner and the snake-body logic.
interface food_spawner_if;
   logic       query_valid;
   logic [9:0] query_x;
   logic [8:0] query_y;
   logic       query_ack;
   logic       query_hit;
   modport master (output query_valid, query_x, query_y, input query_ack, query_hit);
   modport slave  (input query_valid, query_x, query_y, output query_ack, query_hit);
endinterface

// File: rtl/food_spawner.sv
// food_spawner: places food on a random free grid cell, retrying while the snake occupies it.
// Define FOOD_FAIL_HOLD_EN to report spawn_fail and keep the old food when retries run out.
module food_spawner #(
   parameter int CELL      = 10,
   parameter int X_LIMIT   = 600,
   parameter int Y_LIMIT   = 470,
   parameter int MAX_TRIES = 15
) (
   input  logic           VGA_clk,
   input  logic           rst_n,
   input  logic [9:0]     randX,
   input  logic [8:0]     randY,
   input  logic           spawn_req,
   food_spawner_if.master qry,
   output logic [9:0]     foodX,
   output logic [8:0]     foodY,
   output logic           food_valid,
   output logic           spawn_done,
   output logic           spawn_fail,
   output logic           busy
);
   typedef enum logic [2:0] {IDLE, SAMPLE, QUERY, PLACE, FAIL} spawnState_t;
   localparam logic [9:0] cellX    = 10'(CELL);
   localparam logic [8:0] cellY    = 9'(CELL);
   localparam logic [9:0] xLim     = 10'(X_LIMIT);
   localparam logic [8:0] yLim     = 9'(Y_LIMIT);
   localparam logic [7:0] triesMax = 8'(MAX_TRIES);
   spawnState_t state;
   logic [9:0]  cx, snapX;
   logic [8:0]  cy, snapY;
   logic [7:0]  tries;
   logic        pending;
   assign snapX = randX / cellX * cellX;
   assign snapY = randY / cellY * cellY;
   assign qry.query_x = cx;
   assign qry.query_y = cy;
`ifndef FOOD_FAIL_HOLD_EN
   assign spawn_fail = 1'b0;
`endif
   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cx              <= '0;
         cy              <= '0;
         tries           <= '0;
         pending         <= 1'b0;
         qry.query_valid <= 1'b0;
         foodX           <= '0;
         foodY           <= '0;
         food_valid      <= 1'b0;
         spawn_done      <= 1'b0;
`ifdef FOOD_FAIL_HOLD_EN
         spawn_fail      <= 1'b0;
`endif
         busy            <= 1'b0;
      end else begin
         spawn_done <= 1'b0;
`ifdef FOOD_FAIL_HOLD_EN
         spawn_fail <= 1'b0;
`endif
         // only one request is remembered while a spawn is in flight
         if (spawn_req && state != IDLE) pending <= 1'b1;
         case (state)
            IDLE: if (spawn_req || pending) begin
               state      <= SAMPLE;
               busy       <= 1'b1;
               food_valid <= 1'b0;
               tries      <= '0;
               pending    <= 1'b0;
            end
            SAMPLE: begin
               cx              <= snapX > xLim ? xLim : snapX;
               cy              <= snapY > yLim ? yLim : snapY;
               qry.query_valid <= 1'b1;
               state           <= QUERY;
            end
            QUERY: if (qry.query_ack) begin
               qry.query_valid <= 1'b0;
               tries           <= qry.query_hit ? tries + 8'd1 : tries;
               state           <= !qry.query_hit ? PLACE : (tries + 8'd1 == triesMax) ? FAIL : SAMPLE;
            end
            PLACE: begin
               foodX      <= cx;
               foodY      <= cy;
               food_valid <= 1'b1;
               spawn_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            FAIL: begin
`ifdef FOOD_FAIL_HOLD_EN
               spawn_fail <= 1'b1;
`else
               foodX      <= cx;
               foodY      <= cy;
               food_valid <= 1'b1;
               spawn_done <= 1'b1;
`endif
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: directed spawns with a scoreboard of expected queries and completions.
module tb_food_spawner;
   typedef struct {
      bit         fail;
      logic [9:0] x;
      logic [8:0] y;
      bit         valid;
      int         reqCyc;
      int         lat;
   } done_t;
   typedef struct {
      logic [9:0] x;
      logic [8:0] y;
   } qry_t;

   logic       VGA_clk;
   logic       rst_n;
   logic [9:0] randX;
   logic [8:0] randY;
   logic       spawn_req;
   logic [9:0] foodX;
   logic [8:0] foodY;
   logic       food_valid, spawn_done, spawn_fail, busy;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   done_t      doneQ[$];
   qry_t       qQ[$];
   done_t      de;
   qry_t       qe;
   bit         prevPulse = 0;

   food_spawner_if qif();

   food_spawner dut (
      .VGA_clk   (VGA_clk),
      .rst_n     (rst_n),
      .randX     (randX),
      .randY     (randY),
      .spawn_req (spawn_req),
      .qry       (qif),
      .foodX     (foodX),
      .foodY     (foodY),
      .food_valid(food_valid),
      .spawn_done(spawn_done),
      .spawn_fail(spawn_fail),
      .busy      (busy)
   );

   initial VGA_clk = 1'b0;
   always #5 VGA_clk = ~VGA_clk;
   always @(posedge VGA_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge VGA_clk);
         #1;
      end
   endtask

   task automatic checkResetVals(input string tag);
      check({tag, " foodX"}, foodX, 0);
      check({tag, " foodY"}, foodY, 0);
      check({tag, " food_valid"}, food_valid, 0);
      check({tag, " query_valid"}, qif.query_valid, 0);
      check({tag, " query_x"}, qif.query_x, 0);
      check({tag, " query_y"}, qif.query_y, 0);
      check({tag, " spawn_done"}, spawn_done, 0);
      check({tag, " spawn_fail"}, spawn_fail, 0);
      check({tag, " busy"}, busy, 0);
   endtask

   task automatic expectQuery(input logic [9:0] x, input logic [8:0] y);
      qry_t q;
      q.x = x;
      q.y = y;
      qQ.push_back(q);
   endtask

   task automatic expectDone(input bit fail, input logic [9:0] x, input logic [8:0] y,
                             input bit valid, input int lat);
      done_t d;
      d.fail = fail;
      d.x = x;
      d.y = y;
      d.valid = valid;
      d.reqCyc = cyc;
      d.lat = lat;
      doneQ.push_back(d);
   endtask

   task automatic request(input logic [9:0] rx, input logic [8:0] ry);
      randX = rx;
      randY = ry;
      spawn_req = 1'b1;
      tick(1);
      spawn_req = 1'b0;
   endtask

   // waits for the query, holds ack off for `delay` cycles with hit noise, then acks
   task automatic doQuery(input logic [9:0] ex, input logic [8:0] ey, input int delay, input bit hit);
      int n = 0;
      while (!qif.query_valid && n < 20) begin
         tick(1);
         n++;
      end
      check("query_valid arrives", qif.query_valid, 1);
      for (int i = 0; i < delay; i++) begin
         qif.query_hit = 1'b1;
         check("held query_valid", qif.query_valid, 1);
         check("held query_x", qif.query_x, ex);
         check("held query_y", qif.query_y, ey);
         check("no spawn_done before ack", spawn_done, 0);
         tick(1);
      end
      qif.query_ack = 1'b1;
      qif.query_hit = hit;
      tick(1);
      qif.query_ack = 1'b0;
      qif.query_hit = 1'b0;
      check("query_valid drops after ack", qif.query_valid, 0);
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((busy || doneQ.size() != 0) && n < 60) begin
         tick(1);
         n++;
      end
      check("expected completions delivered", doneQ.size(), 0);
      check("busy low when idle", busy, 0);
   endtask

   always @(negedge VGA_clk) begin
      if (qif.query_valid && qif.query_ack) begin
         if (qQ.size() == 0) check("unexpected query", 1, 0);
         else begin
            qe = qQ.pop_front();
            check("query_x", qif.query_x, qe.x);
            check("query_y", qif.query_y, qe.y);
         end
      end
      if (spawn_done || spawn_fail) begin
         check("done/fail exclusive", spawn_done & spawn_fail, 0);
         check("no back-to-back pulse", prevPulse, 0);
         if (doneQ.size() == 0) check("unexpected completion", 1, 0);
         else begin
            de = doneQ.pop_front();
            check("spawn_fail kind", spawn_fail, de.fail);
            check("spawn_done kind", spawn_done, !de.fail);
            check("foodX", foodX, de.x);
            check("foodY", foodY, de.y);
            check("food_valid", food_valid, de.valid);
            if (de.lat > 0) check("latency", cyc - de.reqCyc, de.lat);
         end
      end
      prevPulse = spawn_done | spawn_fail;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      randX = '0;
      randY = '0;
      spawn_req = 1'b0;
      qif.query_ack = 1'b0;
      qif.query_hit = 1'b0;
      #2;
      checkResetVals("reset");
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("no spawn without request", busy, 0);

      // basic spawn: 123,457 snaps to 120,450, done 4 cycles after the request
      expectQuery(10'd120, 9'd450);
      expectDone(0, 10'd120, 9'd450, 1, 4);
      request(10'd123, 9'd457);
      doQuery(10'd120, 9'd450, 0, 0);
      waitIdle();

      // clamping at the limits; food_valid clears when the spawn starts
      expectQuery(10'd600, 9'd470);
      expectDone(0, 10'd600, 9'd470, 1, 0);
      request(10'd609, 9'd480);
      check("food_valid clears on start", food_valid, 0);
      doQuery(10'd600, 9'd470, 0, 0);
      waitIdle();
      expectQuery(10'd600, 9'd470);
      expectDone(0, 10'd600, 9'd470, 1, 0);
      request(10'd1023, 9'd511);
      doQuery(10'd600, 9'd470, 0, 0);
      waitIdle();
      expectQuery(10'd0, 9'd0);
      expectDone(0, 10'd0, 9'd0, 1, 0);
      request(10'd9, 9'd9);
      doQuery(10'd0, 9'd0, 0, 0);
      waitIdle();

      // ack delayed 5 cycles, hit noise without ack ignored
      expectQuery(10'd50, 9'd30);
      expectDone(0, 10'd50, 9'd30, 1, 0);
      request(10'd57, 9'd33);
      doQuery(10'd50, 9'd30, 5, 0);
      waitIdle();

      // every query hits: 15 tries then fail handling
      for (int i = 0; i < 15; i++) expectQuery(10'd200, 9'd100);
`ifdef FOOD_FAIL_HOLD_EN
      expectDone(1, 10'd50, 9'd30, 0, 0);
`else
      expectDone(0, 10'd200, 9'd100, 1, 0);
`endif
      request(10'd205, 9'd107);
      for (int i = 0; i < 15; i++) doQuery(10'd200, 9'd100, 0, 1);
      waitIdle();
      tick(3);
      check("no 16th query", qif.query_valid, 0);

      // second request during QUERY is queued, third is dropped
      expectQuery(10'd300, 9'd200);
      expectQuery(10'd450, 9'd310);
      expectDone(0, 10'd300, 9'd200, 1, 0);
      expectDone(0, 10'd450, 9'd310, 1, 0);
      request(10'd300, 9'd200);
      tick(1);
      check("in QUERY before extra requests", qif.query_valid, 1);
      request(10'd455, 9'd318);
      request(10'd455, 9'd318);
      doQuery(10'd300, 9'd200, 0, 0);
      doQuery(10'd450, 9'd310, 0, 0);
      waitIdle();
      tick(10);
      check("third request dropped", busy, 0);

      // reset mid-QUERY with a pending request: everything clears, nothing follows
      request(10'd100, 9'd100);
      tick(1);
      check("in QUERY before reset", qif.query_valid, 1);
      request(10'd100, 9'd100);
      rst_n = 1'b0;
      #1;
      checkResetVals("mid-query reset");
      @(posedge VGA_clk);
      #1;
      rst_n = 1'b1;
      tick(10);
      check("idle after reset", busy, 0);
      check("no query after reset", qif.query_valid, 0);
      check("no food after reset", food_valid, 0);
      check("leftover expected queries", qQ.size(), 0);
      check("leftover expected completions", doneQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
